// File: rtl/uart_word_pkg.sv
// Shared types and constants for the UART receive word assembler.
package uart_word_pkg;

    localparam int BYTE_W          = 32'sd8;
    localparam int DEFAULT_TIMEOUT = 32'sd1024;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/uart_idle_timer.sv
// Counts idle cycles while enabled; expire is asserted combinationally in the
// cycle whose edge would complete TIMEOUT_CYCLES idle edges.
module uart_idle_timer
    import uart_word_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit TIMER_ON = (TIMEOUT_CYCLES > 32'sd0);
    localparam int CNT_W    = TIMER_ON ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 32'sd1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMER_ON ? TIMEOUT_CYCLES - 32'sd1 : 32'sd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    logic [CNT_W-1:0] idle_cnt_r;

    // Expiry decode: a disabled timer (TIMEOUT_CYCLES = 0) never fires.
    always_comb begin
        expire = 1'b0;
        if (TIMER_ON && enable && !clear && (idle_cnt_r == LAST_CNT)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

    // Idle counter; restarts on expiry so a fresh word gets a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_r <= '0;
        end else if (clear || !TIMER_ON) begin
            idle_cnt_r <= '0;
        end else if (enable && !expire) begin
            idle_cnt_r <= idle_cnt_r + CNT_ONE;
        end else begin
            idle_cnt_r <= '0;
        end
    end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes LSB-first into words and presents each word on a
// valid/ready holding register, with idle timeout, overrun flag and flush.
module uart_rx_word_assembler
    import uart_word_pkg::*;
#(
    parameter int WORD_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         byte_valid,
    input  logic [BYTE_W-1:0]            byte_in,
    input  logic                         flush,
    output logic [BYTE_W*WORD_BYTES-1:0] word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         overrun,
    output logic                         timeout_err,
    output logic                         busy
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int IDX_W  = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'sd1);

    asm_state_t        state_r, state_s;
    hold_state_t       hold_r, hold_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [WORD_W-1:0] shift_r, shift_s, full_word_s;
    logic [WORD_W-1:0] word_r, word_s;
    logic              overrun_r, overrun_s;
    logic              timeout_r, timeout_s;
    logic              busy_r;
    logic              byte_acc_s, word_done_s;
    logic              expire_s, timer_en_s, timer_clear_s;

    // A byte arriving alongside flush is dropped, so it must not feed the timer either.
    assign timer_en_s    = (state_r == COLLECT);
    assign timer_clear_s = byte_valid || flush || (state_r == IDLE);

    uart_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .expire (expire_s)
    );

    // Assembly FSM: byte index, shift register and completed-word detection.
    always_comb begin
        byte_acc_s  = byte_valid && !flush;
        word_done_s = byte_acc_s && (idx_r == LAST_IDX);
        full_word_s = shift_r;
        full_word_s[BYTE_W*(WORD_BYTES-1) +: BYTE_W] = byte_in;
        state_s = state_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        if (byte_acc_s) begin
            shift_s[BYTE_W*idx_r +: BYTE_W] = byte_in;
        end else begin
            shift_s = shift_r;
        end
        if (flush) begin
            state_s = IDLE;
            idx_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (byte_acc_s) begin
                        state_s = COLLECT;
                        idx_s   = IDX_ONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                COLLECT: begin
                    if (word_done_s || (!byte_acc_s && expire_s)) begin
                        state_s = IDLE;
                        idx_s   = '0;
                    end else if (byte_acc_s) begin
                        idx_s = idx_r + IDX_ONE;
                    end else begin
                        state_s = COLLECT;
                    end
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = '0;
                end
            endcase
        end
    end

    // Holding register: load, simultaneous drain-and-load, overrun drop, drain.
    always_comb begin
        hold_s    = hold_r;
        word_s    = word_r;
        overrun_s = 1'b0;
        timeout_s = 1'b0;
        if (flush) begin
            hold_s = EMPTY;
        end else begin
            timeout_s = expire_s;
            case (hold_r)
                EMPTY: begin
                    if (word_done_s) begin
                        hold_s = FULL;
                        word_s = full_word_s;
                    end else begin
                        hold_s = EMPTY;
                    end
                end
                FULL: begin
                    if (word_done_s && word_ready) begin
                        word_s = full_word_s;
                    end else if (word_done_s) begin
                        overrun_s = 1'b1;
                    end else if (word_ready) begin
                        hold_s = EMPTY;
                    end else begin
                        hold_s = FULL;
                    end
                end
                default: begin
                    hold_s = EMPTY;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            shift_r   <= '0;
            hold_r    <= EMPTY;
            word_r    <= '0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            shift_r   <= shift_s;
            hold_r    <= hold_s;
            word_r    <= word_s;
            overrun_r <= overrun_s;
            timeout_r <= timeout_s;
            busy_r    <= (idx_s != '0);
        end
    end

    assign word_out    = word_r;
    assign word_valid  = (hold_r == FULL);
    assign overrun     = overrun_r;
    assign timeout_err = timeout_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed and randomized bench for uart_rx_word_assembler against a
// byte-queue reference model.
module tb_uart_rx_word_assembler;

    localparam int WB = 2;
    localparam int TO = 8;
    localparam int WW = 8 * WB;

    logic          clk = 1'b0;
    logic          rst;
    logic          byte_valid;
    logic [7:0]    byte_in;
    logic          flush;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic          overrun;
    logic          timeout_err;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]    m_bytes[$];
    int            m_idle;
    logic [WW-1:0] m_word;
    logic          m_valid, m_overrun, m_timeout, m_busy;

    always #5 clk = ~clk;

    uart_rx_word_assembler #(
        .WORD_BYTES     (WB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .flush       (flush),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic model_reset();
        m_bytes.delete();
        m_idle    = 0;
        m_word    = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_timeout = 1'b0;
        m_busy    = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic [WW-1:0] w;
        bit done;
        w = '0;
        done = 0;
        m_overrun = 1'b0;
        m_timeout = 1'b0;
        if (flush) begin
            m_bytes.delete();
            m_idle  = 0;
            m_valid = 1'b0;
        end else begin
            if (byte_valid) begin
                m_bytes.push_back(byte_in);
                m_idle = 0;
                if (m_bytes.size() == WB) begin
                    for (int k = 0; k < WB; k++) w[8*k +: 8] = m_bytes[k];
                    m_bytes.delete();
                    done = 1;
                end
            end else if (m_bytes.size() > 0) begin
                m_idle++;
                if (TO > 0 && m_idle == TO) begin
                    m_bytes.delete();
                    m_idle    = 0;
                    m_timeout = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || word_ready) begin
                    m_word  = w;
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 1'b0;
            end
        end
        m_busy = (m_bytes.size() > 0);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        byte_valid = 1'b0; byte_in = 8'h00; flush = 1'b0; word_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({word_out, word_valid, overrun, timeout_err, busy} !== {{WW{1'b0}}, 4'b0000})
            $display("FAIL reset_outputs: got %h/%b%b%b%b want 0/0000", word_out, word_valid, overrun, timeout_err, busy);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send(8'h34);
        n_checks++;
        if (busy !== 1'b1 || word_valid !== 1'b0) $display("FAIL basic_first_byte: got busy=%b valid=%b want 1 0", busy, word_valid);
        else n_pass++;
        send(8'h12);
        n_checks++;
        if (word_out !== 16'h1234 || word_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_word: got %h valid=%b busy=%b want 1234 1 0", word_out, word_valid, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (word_valid !== 1'b0) $display("FAIL basic_drain: got valid=%b want 0", word_valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        send(8'hAA); send(8'hBB);
        send(8'hCC); send(8'hDD);
        n_checks++;
        if (overrun !== 1'b1 || word_out !== 16'hBBAA || word_valid !== 1'b1)
            $display("FAIL overrun_pulse: got ovr=%b word=%h valid=%b want 1 bbaa 1", overrun, word_out, word_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (overrun !== 1'b0 || word_valid !== 1'b1) $display("FAIL overrun_single: got ovr=%b valid=%b want 0 1", overrun, word_valid);
        else n_pass++;
        word_ready = 1'b1;
        tick();
        n_checks++;
        if (word_valid !== 1'b0 || word_out !== 16'hBBAA) $display("FAIL overrun_consume: got valid=%b word=%h want 0 bbaa", word_valid, word_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send(8'h11); send(8'h11);
        send(8'h22);
        word_ready = 1'b1;
        send(8'h22);
        n_checks++;
        if (word_out !== 16'h2222 || word_valid !== 1'b1 || overrun !== 1'b0)
            $display("FAIL drain_and_load: got word=%h valid=%b ovr=%b want 2222 1 0", word_out, word_valid, overrun);
        else n_pass++;
        tick();
        n_checks++;
        if (word_valid !== 1'b0) $display("FAIL drain_after_load: got valid=%b want 0", word_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        word_ready = 1'b1;
        send(8'h55);
        idle(TO - 1);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early: got terr=%b busy=%b want 0 1", timeout_err, busy);
        else n_pass++;
        idle(1);
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_fire: got terr=%b busy=%b want 1 0", timeout_err, busy);
        else n_pass++;
        idle(1);
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_one_cycle: got terr=%b want 0", timeout_err);
        else n_pass++;
        send(8'h01); send(8'h02);
        n_checks++;
        if (word_out !== 16'h0201 || word_valid !== 1'b1) $display("FAIL timeout_recover: got %h valid=%b want 0201 1", word_out, word_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout_boundary();
        word_ready = 1'b1;
        send(8'h55);
        idle(TO - 1);
        send(8'h66);
        n_checks++;
        if (timeout_err !== 1'b0 || word_out !== 16'h6655 || word_valid !== 1'b1)
            $display("FAIL byte_beats_timeout: got terr=%b word=%h valid=%b want 0 6655 1", timeout_err, word_out, word_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        int pulses;
        word_ready = 1'b0;
        send(8'h21); send(8'h43);
        send(8'hEF);
        flush = 1'b1; byte_valid = 1'b1; byte_in = 8'h99;
        tick();
        flush = 1'b0; byte_valid = 1'b0;
        n_checks++;
        if ({word_valid, busy, overrun, timeout_err} !== 4'b0000)
            $display("FAIL flush_clear: got valid/busy/ovr/terr=%b%b%b%b want 0000", word_valid, busy, overrun, timeout_err);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 2 * TO; i++) begin
            tick();
            if (timeout_err === 1'b1 || overrun === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL flush_no_pulse: got %0d pulses want 0", pulses);
        else n_pass++;
        word_ready = 1'b1;
        send(8'hEF); send(8'hBE);
        n_checks++;
        if (word_out !== 16'hBEEF || word_valid !== 1'b1) $display("FAIL flush_next_word: got %h valid=%b want beef 1", word_out, word_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_word();
        word_ready = 1'b0;
        send(8'h77); send(8'h88);
        send(8'hEF);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({word_valid, busy, overrun, timeout_err} !== 4'b0000 || word_out !== 16'h0000)
            $display("FAIL rst_mid_word: got valid/busy/ovr/terr=%b%b%b%b word=%h want 0000 0000", word_valid, busy, overrun, timeout_err, word_out);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        word_ready = 1'b1;
        send(8'hEF); send(8'hBE);
        n_checks++;
        if (word_out !== 16'hBEEF || word_valid !== 1'b1 || timeout_err !== 1'b0)
            $display("FAIL rst_next_word: got %h valid=%b terr=%b want beef 1 0", word_out, word_valid, timeout_err);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            flush      = ($urandom_range(0, 63) == 0);
            byte_valid = ((cyc % 100) > 70) ? 1'b0 : 1'($urandom_range(0, 1));
            byte_in    = 8'($urandom);
            word_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if ({word_out, word_valid, overrun, timeout_err, busy} !== {m_word, m_valid, m_overrun, m_timeout, m_busy})
                $display("FAIL random_cycle_%0d: got %h/%b%b%b%b want %h/%b%b%b%b", cyc,
                         word_out, word_valid, overrun, timeout_err, busy,
                         m_word, m_valid, m_overrun, m_timeout, m_busy);
            else n_pass++;
        end
        flush = 1'b0; byte_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_flush();
        test_reset_mid_word();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
